// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: deterministic stochastic-computing multiplier using clock-division SNG counters
module dsc_mul_seq #(
    parameter int SNG_WIDTH  = 10,
    parameter int NUM_INPUTS = 4,
    parameter bit EARLY_STOP = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  din,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z,
    output logic                             ov
);
    localparam int W  = SNG_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int ZW = N * W;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [W-1:0] C_MAX = '1;
    localparam logic [W-1:0] C_ONE = W'(1);

    logic [1:0]            state_q, state_d;
    logic [N-1:0][W-1:0]   x_q, x_d, c_q, c_d;
    logic [ZW-1:0]         z_q, z_d;
    logic                  ov_q, ov_d, busy_q, done_q;
    logic [N:0]            pre;
    logic                  m, any_zero, full_w, early;

    // pre[k] = counters 0..k-1 all at max, i.e. counter k steps this cycle
    always_comb begin
        pre      = '0;
        pre[0]   = 1'b1;
        m        = 1'b1;
        any_zero = 1'b0;
        for (int k = 0; k < N; k++) begin
            pre[k+1] = pre[k] & (c_q[k] == C_MAX);
            m        = m & (c_q[k] < x_q[k]);
            any_zero = any_zero | (din[k*W +: W] == '0);
        end
        full_w = pre[N];
        early  = EARLY_STOP && pre[N-1] && (c_q[N-1] == x_q[N-1] - C_ONE);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        c_d     = c_q;
        z_d     = z_q;
        ov_d    = ov_q;
        if (state_q == S_RUN) begin
            z_d = z_q + ZW'(m);
            for (int k = 0; k < N; k++)
                c_d[k] = pre[k] ? c_q[k] + C_ONE : c_q[k];
            if (early || full_w) begin
                state_d = S_DONE;
                ov_d    = early;
            end
        end else if (start) begin
            x_d     = din;
            c_d     = '0;
            z_d     = '0;
            ov_d    = any_zero;
            state_d = any_zero ? S_DONE : S_RUN;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            c_q     <= '0;
            z_q     <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            c_q     <= c_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign ov   = ov_q;
endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: scoreboard bench over four multiplier configurations
module tb_dsc_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
    logic [5:0]  din_ab = '0;
    logic [11:0] din_c  = '0;
    logic [3:0]  din_d  = '0;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic ov_a, ov_b, ov_c, ov_d;
    logic [5:0]  z_a, z_b;
    logic [11:0] z_c;
    logic [3:0]  z_d;
    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    int cn[4]  = '{2, 2, 3, 1};
    int cw[4]  = '{3, 3, 4, 4};
    bit ces[4] = '{1, 0, 1, 1};

    always #5 clk = ~clk;

    dsc_mul_seq #(.SNG_WIDTH(3), .NUM_INPUTS(2), .EARLY_STOP(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .din(din_ab),
        .busy(busy_a), .done(done_a), .z(z_a), .ov(ov_a));
    dsc_mul_seq #(.SNG_WIDTH(3), .NUM_INPUTS(2), .EARLY_STOP(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .din(din_ab),
        .busy(busy_b), .done(done_b), .z(z_b), .ov(ov_b));
    dsc_mul_seq #(.SNG_WIDTH(4), .NUM_INPUTS(3), .EARLY_STOP(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .din(din_c),
        .busy(busy_c), .done(done_c), .z(z_c), .ov(ov_c));
    dsc_mul_seq #(.SNG_WIDTH(4), .NUM_INPUTS(1), .EARLY_STOP(1)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .din(din_d),
        .busy(busy_d), .done(done_d), .z(z_d), .ov(ov_d));

    function automatic logic dn(int s);
        case (s)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    function automatic logic bs(int s);
        case (s)
            0: return busy_a;
            1: return busy_b;
            2: return busy_c;
            default: return busy_d;
        endcase
    endfunction

    function automatic logic ovv(int s);
        case (s)
            0: return ov_a;
            1: return ov_b;
            2: return ov_c;
            default: return ov_d;
        endcase
    endfunction

    function automatic logic [11:0] zv(int s);
        case (s)
            0: return {6'b0, z_a};
            1: return {6'b0, z_b};
            2: return z_c;
            default: return {8'b0, z_d};
        endcase
    endfunction

    function automatic int field(logic [11:0] d, int k, int w);
        return int'(d >> (k * w)) & ((1 << w) - 1);
    endfunction

    function automatic logic [11:0] model_z(logic [11:0] d, int n, int w);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * field(d, k, w);
        return 12'(p);
    endfunction

    function automatic bit model_zero(logic [11:0] d, int n, int w);
        for (int k = 0; k < n; k++) if (field(d, k, w) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_cyc(logic [11:0] d, int n, int w, bit es);
        if (model_zero(d, n, w)) return 0;
        if (!es) return 1 << (n * w);
        return field(d, n - 1, w) << ((n - 1) * w);
    endfunction

    task automatic run_op(input int s, input logic [11:0] d, input int limit,
                          output int cyc, output int wt, output bit seen);
        exp_q.push_back(model_z(d, cn[s], cw[s]));
        case (s)
            0: begin din_ab = d[5:0]; start_a = 1'b1; end
            1: begin din_ab = d[5:0]; start_b = 1'b1; end
            2: begin din_c = d; start_c = 1'b1; end
            default: begin din_d = d[3:0]; start_d = 1'b1; end
        endcase
        @(negedge clk);
        {start_a, start_b, start_c, start_d} = '0;
        cyc = 0;
        wt = 0;
        seen = 1'b0;
        while (!seen && wt < limit) begin
            if (dn(s)) seen = 1'b1;
            else begin
                cyc += int'(bs(s));
                wt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({bs(s), dn(s), ovv(s), zv(s)} !== 15'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got busy=%0b done=%0b ov=%0b z=%0d want all 0",
                         s, bs(s), dn(s), ovv(s), zv(s));
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got busy=%0b done=%0b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_basic();
        int ts[8];
        logic [11:0] td[8];
        int cyc, wt, ecyc;
        bit seen, eov;
        logic [11:0] ez;
        ts = '{0, 1, 0, 1, 2, 3, 0, 3};
        td = '{12'o35, 12'o35, 12'o77, 12'o77, 12'hFFF, 12'd9, 12'o70, 12'd0};
        for (int i = 0; i < 8; i++) begin
            run_op(ts[i], td[i], 5000, cyc, wt, seen);
            ez   = exp_q.pop_front();
            ecyc = model_cyc(td[i], cn[ts[i]], cw[ts[i]], ces[ts[i]]);
            eov  = model_zero(td[i], cn[ts[i]], cw[ts[i]]) || ces[ts[i]];
            checks++;
            if (!seen || zv(ts[i]) !== ez) begin
                errors++;
                $display("FAIL basic_z[%0d] got %0d (done=%0b) want %0d", i, zv(ts[i]), seen, ez);
            end
            checks++;
            if (cyc !== ecyc) begin
                errors++;
                $display("FAIL basic_busy_cycles[%0d] got %0d want %0d", i, cyc, ecyc);
            end
            checks++;
            if (wt !== ecyc) begin
                errors++;
                $display("FAIL basic_done_latency[%0d] got %0d want %0d", i, wt, ecyc);
            end
            checks++;
            if (ovv(ts[i]) !== eov) begin
                errors++;
                $display("FAIL basic_ov[%0d] got %0b want %0b", i, ovv(ts[i]), eov);
            end
            repeat (3) @(negedge clk);
            checks++;
            if ({dn(ts[i]), bs(ts[i]), ovv(ts[i]), zv(ts[i])} !== {1'b0, 1'b0, eov, ez}) begin
                errors++;
                $display("FAIL basic_hold[%0d] got done=%0b busy=%0b ov=%0b z=%0d want 0 0 %0b %0d",
                         i, dn(ts[i]), bs(ts[i]), ovv(ts[i]), zv(ts[i]), eov, ez);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc = 0;
        bit seen = 1'b0;
        logic [11:0] ez;
        exp_q.push_back(model_z(12'o56, 2, 3));
        din_ab = 6'o56;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (i == 5) begin din_ab = 6'o77; start_a = 1'b1; end
            if (i == 6) start_a = 1'b0;
            if (done_a) seen = 1'b1;
            else begin
                cyc += int'(busy_a);
                @(negedge clk);
            end
        end
        ez = exp_q.pop_front();
        checks++;
        if (!seen || {6'b0, z_a} !== ez) begin
            errors++;
            $display("FAIL ignore_start_z got %0d (done=%0b) want %0d", z_a, seen, ez);
        end
        checks++;
        if (cyc !== model_cyc(12'o56, 2, 3, 1'b1)) begin
            errors++;
            $display("FAIL ignore_start_cycles got %0d want %0d", cyc, model_cyc(12'o56, 2, 3, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc, wt;
        bit seen;
        logic [11:0] ez;
        din_ab = 6'o35;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got %0b want 1", busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        checks++;
        if ({busy_a, done_a, ov_a, z_a} !== 9'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%0b done=%0b ov=%0b z=%0d want all 0",
                     busy_a, done_a, ov_a, z_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, z_a} !== 8'b0) begin
            errors++;
            $display("FAIL midrun_idle got busy=%0b done=%0b z=%0d want 0 0 0", busy_a, done_a, z_a);
        end
        run_op(0, 12'o22, 200, cyc, wt, seen);
        ez = exp_q.pop_front();
        checks++;
        if (!seen || {6'b0, z_a} !== ez) begin
            errors++;
            $display("FAIL midrun_restart_z got %0d (done=%0b) want %0d", z_a, seen, ez);
        end
        checks++;
        if (cyc !== model_cyc(12'o22, 2, 3, 1'b1)) begin
            errors++;
            $display("FAIL midrun_restart_cycles got %0d want %0d", cyc, model_cyc(12'o22, 2, 3, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [11:0] ez;
        for (int p = 0; p < 64; p++) begin
            din_ab = 6'(p);
            start_a = 1'b1;
            exp_q.push_back(model_z(12'(p), 2, 3));
            @(negedge clk);
            start_a = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 80 && !seen; i++) begin
                if (done_a) seen = 1'b1;
                else @(negedge clk);
            end
            ez = exp_q.pop_front();
            checks++;
            if (!seen || {6'b0, z_a} !== ez) begin
                errors++;
                $display("FAIL sweep x0=%0d x1=%0d got %0d (done=%0b) want %0d",
                         p % 8, p / 8, z_a, seen, ez);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
